ex_operand_stage: RTL and testbench

Registered ID/EX boundary that feeds the ALU. Each cycle it accepts one decoded instruction, selects the ALU `a`/`b` operands from register data, shift amount, or extended immediate, and applies EX/WB forwarding. It detects load-use hazards and stalls on them, then presents `alu_a`/`alu_b`/`alu_aluc` from a single output register under a valid/ready handshake. Downstream, the ALU output and flags are consumed combinationally alongside `out_dst`/`out_wen`.

---
 rtl/alu_pkg.sv | 71 +++++++
 rtl/ex_operand_stage_if.sv | 55 +++++
 rtl/fwd_mux.sv | 32 +++
 rtl/ex_operand_stage.sv | 119 +++++++++++
 tb/tb_ex_operand_stage.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath widths, ALUC op codes, operand-select encodings
// and the payload types carried across the ID/EX boundary.
package alu_pkg;

    localparam int unsigned DW      = 32;
    localparam int unsigned RW      = 5;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned IMM_W   = 16;
    localparam int unsigned SHAMT_W = 5;

    // LUI and SLL ignore the low bit of the op code
    localparam logic [ALUC_W-1:0] ALUC_ADDU = 4'b0000;
    localparam logic [ALUC_W-1:0] ALUC_SUBU = 4'b0001;
    localparam logic [ALUC_W-1:0] ALUC_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALUC_SUB  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALUC_AND  = 4'b0100;
    localparam logic [ALUC_W-1:0] ALUC_OR   = 4'b0101;
    localparam logic [ALUC_W-1:0] ALUC_XOR  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALUC_NOR  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALUC_LUI  = 4'b1000;
    localparam logic [ALUC_W-1:0] ALUC_SLTU = 4'b1010;
    localparam logic [ALUC_W-1:0] ALUC_SLT  = 4'b1011;
    localparam logic [ALUC_W-1:0] ALUC_SRA  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALUC_SRL  = 4'b1101;
    localparam logic [ALUC_W-1:0] ALUC_SLL  = 4'b1110;

    typedef enum logic [1:0] {
        A_SEL_RS    = 2'b00,
        A_SEL_SHAMT = 2'b01,
        A_SEL_ZERO  = 2'b10,
        A_SEL_RSVD  = 2'b11
    } a_sel_e;

    typedef enum logic [1:0] {
        B_SEL_RT   = 2'b00,
        B_SEL_SIMM = 2'b01,
        B_SEL_ZIMM = 2'b10,
        B_SEL_RSVD = 2'b11
    } b_sel_e;

    typedef struct packed {
        logic          ex_valid;
        logic [RW-1:0] ex_addr;
        logic [DW-1:0] ex_data;
        logic          ex_is_load;
        logic          wb_valid;
        logic [RW-1:0] wb_addr;
        logic [DW-1:0] wb_data;
    } fwd_bundle_t;

    typedef struct packed {
        logic [DW-1:0]     a;
        logic [DW-1:0]     b;
        logic [ALUC_W-1:0] aluc;
        logic [RW-1:0]     dst;
        logic              wen;
    } ex_payload_t;

    function automatic logic [DW-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DW-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    function automatic logic [DW-1:0] zext_imm(input logic [IMM_W-1:0] imm);
        return DW'(imm);
    endfunction

    function automatic logic [DW-1:0] zext_shamt(input logic [SHAMT_W-1:0] shamt);
        return DW'(shamt);
    endfunction

endpackage

// File: rtl/ex_operand_stage_if.sv
// Signal bundle between the decode side, the forwarding network, the operand stage and the ALU.
// master = environment around the stage, slave = the stage itself.
interface ex_operand_stage_if;
    import alu_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ALUC_W-1:0]     in_aluc;
    logic [1:0]            in_a_sel;
    logic [1:0]            in_b_sel;
    logic [DW-1:0]         in_rs_data;
    logic [DW-1:0]         in_rt_data;
    logic [RW-1:0]         in_rs_addr;
    logic [RW-1:0]         in_rt_addr;
    logic [SHAMT_W-1:0]    in_shamt;
    logic [IMM_W-1:0]      in_imm;
    logic [RW-1:0]         in_dst;
    logic                  in_wen;

    logic                  fwd_ex_valid;
    logic [RW-1:0]         fwd_ex_addr;
    logic [DW-1:0]         fwd_ex_data;
    logic                  fwd_ex_is_load;
    logic                  fwd_wb_valid;
    logic [RW-1:0]         fwd_wb_addr;
    logic [DW-1:0]         fwd_wb_data;

    logic                  flush;

    logic                  out_valid;
    logic                  out_ready;
    logic [DW-1:0]         alu_a;
    logic [DW-1:0]         alu_b;
    logic [ALUC_W-1:0]     alu_aluc;
    logic [RW-1:0]         out_dst;
    logic                  out_wen;
    logic                  hazard_stall;

    modport master (
        output in_valid, in_aluc, in_a_sel, in_b_sel, in_rs_data, in_rt_data,
               in_rs_addr, in_rt_addr, in_shamt, in_imm, in_dst, in_wen,
               fwd_ex_valid, fwd_ex_addr, fwd_ex_data, fwd_ex_is_load,
               fwd_wb_valid, fwd_wb_addr, fwd_wb_data, flush, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_aluc, out_dst, out_wen, hazard_stall
    );

    modport slave (
        input  in_valid, in_aluc, in_a_sel, in_b_sel, in_rs_data, in_rt_data,
               in_rs_addr, in_rt_addr, in_shamt, in_imm, in_dst, in_wen,
               fwd_ex_valid, fwd_ex_addr, fwd_ex_data, fwd_ex_is_load,
               fwd_wb_valid, fwd_wb_addr, fwd_wb_data, flush, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_aluc, out_dst, out_wen, hazard_stall
    );

endinterface

// File: rtl/fwd_mux.sv
// Resolves one source operand against the EX/MEM and MEM/WB forwarding paths.
// load_hit_o flags a used source that depends on a load still in EX.
module fwd_mux
    import alu_pkg::*;
(
    input  logic          used_i,
    input  logic [RW-1:0] addr_i,
    input  logic [DW-1:0] rf_data_i,
    input  fwd_bundle_t   fwd_i,
    output logic [DW-1:0] data_o,
    output logic          load_hit_o
);

    logic live;
    logic ex_match;
    logic wb_match;

    // $0 is hardwired, so it never matches a forwarding path
    always_comb begin
        live       = used_i && (addr_i != '0);
        ex_match   = live && fwd_i.ex_valid && (fwd_i.ex_addr == addr_i);
        wb_match   = live && fwd_i.wb_valid && (fwd_i.wb_addr == addr_i);
        load_hit_o = ex_match && fwd_i.ex_is_load;
        data_o     = rf_data_i;
        if (ex_match && !fwd_i.ex_is_load) begin
            data_o = fwd_i.ex_data;
        end else if (wb_match) begin
            data_o = fwd_i.wb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX boundary register: operand selection, EX/WB forwarding, load-use stall
// and a single valid/ready output slot feeding the ALU.
module ex_operand_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    ex_operand_stage_if.slave  bus
);

    fwd_bundle_t fwd;
    logic        rs_used;
    logic        rt_used;
    logic [DW-1:0] rs_val;
    logic [DW-1:0] rt_val;
    logic        rs_load_hit;
    logic        rt_load_hit;

    logic        hazard;
    logic        in_ready;
    logic        capture;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;

    ex_payload_t payload_q;
    ex_payload_t payload_d;
    logic        valid_q;
    logic        valid_d;

    always_comb begin
        fwd.ex_valid   = bus.fwd_ex_valid;
        fwd.ex_addr    = bus.fwd_ex_addr;
        fwd.ex_data    = bus.fwd_ex_data;
        fwd.ex_is_load = bus.fwd_ex_is_load;
        fwd.wb_valid   = bus.fwd_wb_valid;
        fwd.wb_addr    = bus.fwd_wb_addr;
        fwd.wb_data    = bus.fwd_wb_data;
    end

    assign rs_used = (bus.in_a_sel == A_SEL_RS);
    assign rt_used = (bus.in_b_sel == B_SEL_RT);

    fwd_mux u_fwd_rs (
        .used_i     (rs_used),
        .addr_i     (bus.in_rs_addr),
        .rf_data_i  (bus.in_rs_data),
        .fwd_i      (fwd),
        .data_o     (rs_val),
        .load_hit_o (rs_load_hit)
    );

    fwd_mux u_fwd_rt (
        .used_i     (rt_used),
        .addr_i     (bus.in_rt_addr),
        .rf_data_i  (bus.in_rt_data),
        .fwd_i      (fwd),
        .data_o     (rt_val),
        .load_hit_o (rt_load_hit)
    );

    // Reserved select codes fall through to the zero / zero-extended choices
    always_comb begin
        op_a = '0;
        op_b = zext_imm(bus.in_imm);
        case (a_sel_e'(bus.in_a_sel))
            A_SEL_RS:    op_a = rs_val;
            A_SEL_SHAMT: op_a = zext_shamt(bus.in_shamt);
            default:     op_a = '0;
        endcase
        case (b_sel_e'(bus.in_b_sel))
            B_SEL_RT:   op_b = rt_val;
            B_SEL_SIMM: op_b = sext_imm(bus.in_imm);
            default:    op_b = zext_imm(bus.in_imm);
        endcase
    end

    assign hazard   = bus.in_valid && (rs_load_hit || rt_load_hit);
    assign in_ready = (!valid_q || bus.out_ready) && !hazard;
    assign capture  = bus.in_valid && in_ready && !bus.flush;

    // Flush wins over capture and drain; capture alone keeps the slot full
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (bus.flush) begin
            valid_d       = 1'b0;
            payload_d.wen = 1'b0;
        end else if (capture) begin
            valid_d        = 1'b1;
            payload_d.a    = op_a;
            payload_d.b    = op_b;
            payload_d.aluc = bus.in_aluc;
            payload_d.dst  = bus.in_dst;
            payload_d.wen  = bus.in_wen;
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.hazard_stall = hazard;
    assign bus.out_valid    = valid_q;
    assign bus.alu_a        = payload_q.a;
    assign bus.alu_b        = payload_q.b;
    assign bus.alu_aluc     = payload_q.aluc;
    assign bus.out_dst      = payload_q.dst;
    assign bus.out_wen      = payload_q.wen;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: operand select, forwarding, load-use stall,
// backpressure, flush and asynchronous reset, each against hand-computed values.
module tb_ex_operand_stage;

    logic clk = 1'b0;
    logic rst;
    int   total_cnt = 0;
    int   pass_cnt  = 0;

    ex_operand_stage_if bus ();

    ex_operand_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic fwd_off();
        bus.fwd_ex_valid   = 1'b0;
        bus.fwd_ex_addr    = '0;
        bus.fwd_ex_data    = '0;
        bus.fwd_ex_is_load = 1'b0;
        bus.fwd_wb_valid   = 1'b0;
        bus.fwd_wb_addr    = '0;
        bus.fwd_wb_data    = '0;
    endtask

    task automatic set_instr(input logic [3:0] aluc, input logic [1:0] a_sel, input logic [1:0] b_sel,
                             input logic [4:0] rs_addr, input logic [31:0] rs_data,
                             input logic [4:0] rt_addr, input logic [31:0] rt_data,
                             input logic [4:0] shamt, input logic [15:0] imm,
                             input logic [4:0] dst, input logic wen);
        bus.in_aluc    = aluc;
        bus.in_a_sel   = a_sel;
        bus.in_b_sel   = b_sel;
        bus.in_rs_addr = rs_addr;
        bus.in_rs_data = rs_data;
        bus.in_rt_addr = rt_addr;
        bus.in_rt_data = rt_data;
        bus.in_shamt   = shamt;
        bus.in_imm     = imm;
        bus.in_dst     = dst;
        bus.in_wen     = wen;
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b0;
        fwd_off();
        set_instr(4'h0, 2'b00, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 16'h0, 5'd0, 1'b0);
        repeat (2) tick();
        check("rst_valid", bus.out_valid, 0);
        check("rst_a", bus.alu_a, 0);
        check("rst_b", bus.alu_b, 0);
        check("rst_wen", bus.out_wen, 0);
        rst = 1'b0;

        // ADD $3,$1,$2
        bus.out_ready = 1'b1;
        set_instr(4'b0010, 2'b00, 2'b00, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 16'h0, 5'd3, 1'b1);
        bus.in_valid = 1'b1;
        #1;
        check("add_in_ready", bus.in_ready, 1);
        check("add_no_stall", bus.hazard_stall, 0);
        tick();
        check("add_valid", bus.out_valid, 1);
        check("add_a", bus.alu_a, 32'd5);
        check("add_b", bus.alu_b, 32'd7);
        check("add_aluc", bus.alu_aluc, 32'h2);
        check("add_dst", bus.out_dst, 32'd3);
        check("add_wen", bus.out_wen, 1);

        // ADDI sign-extended, then ORI zero-extended back-to-back
        set_instr(4'b0000, 2'b00, 2'b01, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 16'hFFFC, 5'd2, 1'b1);
        tick();
        check("addi_a", bus.alu_a, 32'd5);
        check("addi_b", bus.alu_b, 32'hFFFF_FFFC);
        set_instr(4'b0101, 2'b00, 2'b10, 5'd1, 32'd5, 5'd2, 32'd7, 5'd0, 16'hFFFC, 5'd2, 1'b1);
        tick();
        check("ori_b", bus.alu_b, 32'h0000_FFFC);
        check("ori_aluc", bus.alu_aluc, 32'h5);
        check("ori_valid", bus.out_valid, 1);

        // SLL by constant shamt, then reserved select codes
        set_instr(4'b1110, 2'b01, 2'b00, 5'd1, 32'd5, 5'd2, 32'd7, 5'd31, 16'h0, 5'd4, 1'b1);
        tick();
        check("sll_a", bus.alu_a, 32'd31);
        check("sll_b", bus.alu_b, 32'd7);
        set_instr(4'b0000, 2'b11, 2'b11, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 16'h8001, 5'd4, 1'b0);
        tick();
        check("rsvd_a", bus.alu_a, 32'd0);
        check("rsvd_b", bus.alu_b, 32'h0000_8001);
        bus.in_valid = 1'b0;
        tick();
        check("drain_valid", bus.out_valid, 0);

        // Forwarding: EX beats WB, WB alone, $0 never forwarded, rt from WB
        bus.fwd_ex_valid = 1'b1; bus.fwd_ex_addr = 5'd4; bus.fwd_ex_data = 32'd11;
        bus.fwd_wb_valid = 1'b1; bus.fwd_wb_addr = 5'd4; bus.fwd_wb_data = 32'd22;
        set_instr(4'b0000, 2'b00, 2'b01, 5'd4, 32'd1, 5'd0, 32'd0, 5'd0, 16'h0, 5'd5, 1'b1);
        bus.in_valid = 1'b1;
        tick();
        check("fwd_ex_a", bus.alu_a, 32'd11);
        bus.fwd_ex_valid = 1'b0;
        tick();
        check("fwd_wb_a", bus.alu_a, 32'd22);
        bus.fwd_ex_valid = 1'b1; bus.fwd_ex_addr = 5'd0;
        bus.fwd_wb_addr = 5'd0;
        set_instr(4'b0000, 2'b00, 2'b01, 5'd0, 32'h1234, 5'd0, 32'd0, 5'd0, 16'h0, 5'd5, 1'b1);
        tick();
        check("fwd_zero_a", bus.alu_a, 32'h1234);
        fwd_off();
        bus.fwd_wb_valid = 1'b1; bus.fwd_wb_addr = 5'd6; bus.fwd_wb_data = 32'd55;
        set_instr(4'b0000, 2'b10, 2'b00, 5'd0, 32'd0, 5'd6, 32'd3, 5'd0, 16'h0, 5'd5, 1'b1);
        tick();
        check("fwd_wb_b", bus.alu_b, 32'd55);
        fwd_off();
        bus.in_valid = 1'b0;
        tick();
        check("fwd_drain", bus.out_valid, 0);

        // Load-use on rt=$8, then the load advances to WB with data 99
        bus.fwd_ex_valid = 1'b1; bus.fwd_ex_addr = 5'd8; bus.fwd_ex_data = 32'hDEAD;
        bus.fwd_ex_is_load = 1'b1;
        set_instr(4'b0000, 2'b10, 2'b00, 5'd0, 32'd0, 5'd8, 32'd3, 5'd0, 16'h0, 5'd9, 1'b1);
        bus.in_valid = 1'b1;
        #1;
        check("lu_stall", bus.hazard_stall, 1);
        check("lu_not_ready", bus.in_ready, 0);
        tick();
        check("lu_no_capture", bus.out_valid, 0);
        fwd_off();
        bus.fwd_wb_valid = 1'b1; bus.fwd_wb_addr = 5'd8; bus.fwd_wb_data = 32'd99;
        #1;
        check("lu_clear", bus.hazard_stall, 0);
        check("lu_ready", bus.in_ready, 1);
        tick();
        check("lu_valid", bus.out_valid, 1);
        check("lu_b", bus.alu_b, 32'd99);
        fwd_off();

        // Backpressure for 3 cycles, then back-to-back captures
        bus.out_ready = 1'b0;
        set_instr(4'b0000, 2'b00, 2'b01, 5'd9, 32'd100, 5'd0, 32'd0, 5'd0, 16'h0, 5'd9, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_not_ready", bus.in_ready, 0);
            tick();
            check("bp_hold_b", bus.alu_b, 32'd99);
            check("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_ready", bus.in_ready, 1);
        tick();
        check("b2b_first", bus.alu_a, 32'd100);
        bus.in_rs_data = 32'd200;
        tick();
        check("b2b_second", bus.alu_a, 32'd200);
        check("b2b_valid", bus.out_valid, 1);
        bus.in_valid = 1'b0;
        tick();
        check("b2b_drain", bus.out_valid, 0);

        // Flush with a held instruction and a presented one
        bus.in_rs_data = 32'd300;
        bus.in_valid = 1'b1;
        tick();
        check("pre_flush_a", bus.alu_a, 32'd300);
        bus.in_rs_data = 32'd400;
        bus.flush = 1'b1;
        #1;
        check("flush_ready", bus.in_ready, 1);
        tick();
        check("flush_valid", bus.out_valid, 0);
        check("flush_wen", bus.out_wen, 0);
        bus.flush = 1'b0;

        // Asynchronous reset while a load-use stall is pending
        set_instr(4'b0111, 2'b00, 2'b01, 5'd9, 32'd300, 5'd0, 32'd0, 5'd0, 16'h1, 5'd5, 1'b1);
        tick();
        check("pre_rst_valid", bus.out_valid, 1);
        bus.out_ready = 1'b0;
        bus.fwd_ex_valid = 1'b1; bus.fwd_ex_addr = 5'd8; bus.fwd_ex_is_load = 1'b1;
        set_instr(4'b0000, 2'b10, 2'b00, 5'd0, 32'd0, 5'd8, 32'd3, 5'd0, 16'h0, 5'd6, 1'b1);
        #1;
        check("pre_rst_stall", bus.hazard_stall, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", bus.out_valid, 0);
        check("arst_a", bus.alu_a, 0);
        check("arst_b", bus.alu_b, 0);
        check("arst_aluc", bus.alu_aluc, 0);
        check("arst_dst", bus.out_dst, 0);
        check("arst_wen", bus.out_wen, 0);
        #1;
        rst = 1'b0;
        fwd_off();
        bus.out_ready = 1'b1;
        set_instr(4'b0000, 2'b00, 2'b01, 5'd9, 32'd77, 5'd0, 32'd0, 5'd0, 16'h0, 5'd6, 1'b1);
        tick();
        check("post_rst_valid", bus.out_valid, 1);
        check("post_rst_a", bus.alu_a, 32'd77);
        bus.in_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
